// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [7:0]       op_count
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_id;
    logic             grant_any;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic             id_q;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH:0]   alu_diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;

    // Grant selection: a lone requester wins; a tie goes to whoever was not served last
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    // Next-state and handshake outputs; everything is held quiet while rst is high
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        req0_ready = ~grant_id;
                        req1_ready = grant_id;
                        state_nxt  = EXEC;
                    end
                end
                EXEC: state_nxt = RESP;
                RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shared ALU on the captured operands; unknown codes fall through to result 0 (Z only)
    always_comb begin
        alu_sum  = {1'b0, a_q} + {1'b0, b_q};
        alu_diff = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (ctrl_q)
            4'd8: begin
                alu_res = alu_sum[MSB:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            4'd9: begin
                alu_res = alu_diff[MSB:0];
                alu_c   = ~alu_diff[WIDTH];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            4'd10:   alu_res = a_q & b_q;
            4'd11:   alu_res = a_q | b_q;
            4'd12:   alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end

    assign accept = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    // Operand capture, result/flag registration and response bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= 4'd0;
            id_q       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= 4'd0;
            op_count   <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                a_q    <= grant_id ? req1_a : req0_a;
                b_q    <= grant_id ? req1_b : req0_b;
                ctrl_q <= grant_id ? req1_ctrl : req0_ctrl;
                id_q   <= grant_id;
            end
            if (state == EXEC) begin
                rsp_id     <= id_q;
                rsp_result <= alu_res;
                rsp_flags  <= alu_flags;
            end
            if (rsp_valid && rsp_ready) begin
                op_count   <= op_count + 8'd1;
                last_grant <= rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [3:0] req0_ctrl;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [3:0] req1_ctrl;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [7:0] op_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int exp_count = 0;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] ctrl,
                         input logic [3:0] er, input logic [3:0] ef, input string tag);
        int   n;
        logic rdy;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
        end
        #1;
        n   = 0;
        rdy = (id == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 20) begin
            tick();
            n++;
            rdy = (id == 0) ? req0_ready : req1_ready;
        end
        chk({tag, "_grant"}, 32'(rdy), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 0);
        tick();
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_result"}, 32'(rsp_result), 32'(er));
        chk({tag, "_flags"}, 32'(rsp_flags), 32'(ef));
        tick();
        exp_count = (exp_count + 1) % 256;
        chk({tag, "_count"}, 32'(op_count), 32'(exp_count));
        chk({tag, "_idle_valid"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_ctrl = 4'd8;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1; req1_ctrl = 4'd8;
        tick(); tick(); tick();

        // reset state with both requesters already asking
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_result", 32'(rsp_result), 0);
        chk("rst_flags", 32'(rsp_flags), 0);
        chk("rst_count", 32'(op_count), 0);

        // continuous tie: grants alternate 0,1,0,1
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("tie_ready0", 32'(req0_ready), 32'((k + 1) % 2));
            chk("tie_ready1", 32'(req1_ready), 32'(k % 2));
            tick();
            chk("tie_exec_ready", 32'({req0_ready, req1_ready}), 0);
            tick();
            chk("tie_rsp_valid", 32'(rsp_valid), 1);
            chk("tie_rsp_id", 32'(rsp_id), 32'(k % 2));
            chk("tie_result", 32'(rsp_result), 2);
            chk("tie_flags", 32'(rsp_flags), 0);
            chk("tie_resp_ready", 32'({req0_ready, req1_ready}), 0);
            tick();
            if (k == 3) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            exp_count++;
            chk("tie_count", 32'(op_count), 32'(exp_count));
        end

        // single operations: arithmetic, logic and undefined codes
        do_op(0, 4'd7,  4'd3,  4'd8,  4'd10, 4'b1001, "add_7_3");
        do_op(1, 4'd2,  4'd3,  4'd8,  4'd5,  4'b0000, "add_2_3");
        do_op(1, 4'd15, 4'd3,  4'd8,  4'd2,  4'b0010, "add_15_3");
        do_op(0, 4'd3,  4'd3,  4'd9,  4'd0,  4'b0110, "sub_3_3");
        do_op(0, 4'd3,  4'd5,  4'd9,  4'd14, 4'b1000, "sub_3_5");
        do_op(1, 4'd8,  4'd1,  4'd9,  4'd7,  4'b0011, "sub_8_1");
        do_op(1, 4'd12, 4'd10, 4'd10, 4'd8,  4'b1000, "and");
        do_op(0, 4'd5,  4'd10, 4'd11, 4'd15, 4'b1000, "or");
        do_op(1, 4'd9,  4'd9,  4'd12, 4'd0,  4'b0100, "xor");
        do_op(0, 4'd5,  4'd6,  4'd3,  4'd0,  4'b0100, "undef");

        // backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_ctrl = 4'd8;
        #1;
        chk("bp_grant", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_result", 32'(rsp_result), 3);
            chk("bp_flags", 32'(rsp_flags), 0);
            chk("bp_ready", 32'({req0_ready, req1_ready}), 0);
            chk("bp_count", 32'(op_count), 32'(exp_count));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        exp_count++;
        chk("bp_count_after", 32'(op_count), 32'(exp_count));
        chk("bp_valid_after", 32'(rsp_valid), 0);

        // reset while in EXEC drops the operation; next tie goes to req0
        req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4; req1_ctrl = 4'd8;
        #1;
        chk("rexec_grant", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        exp_count = 0;
        chk("rexec_valid", 32'(rsp_valid), 0);
        chk("rexec_count", 32'(op_count), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rexec_no_rsp", 32'(rsp_valid), 0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("rexec_tie0", 32'(req0_ready), 1);
        chk("rexec_tie1", 32'(req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 256 operations wrap op_count back to 0
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_ctrl = 4'd8;
        for (int i = 0; i < 255; i++) begin
            tick(); tick(); tick();
        end
        chk("wrap_255", 32'(op_count), 255);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("wrap_rsp_valid", 32'(rsp_valid), 1);
        tick();
        chk("wrap_zero", 32'(op_count), 0);
        chk("wrap_idle", 32'(rsp_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
